// File: rtl/step_ctrl.sv
`default_nettype none
// ============================================================================
//  step_ctrl
//  Debounced single-step button plus auto-step divider generating a
//  one-cycle step-enable pulse, a latched switch value and a step counter.
//  Revision: 1.0
// ============================================================================
module step_ctrl #(
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned AUTO_PERIOD = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_in,
    input  logic [1:0]       sw_raw,
    input  logic             auto_en,
    output logic             ctrl_out,
    output logic [1:0]       sw_out,
    output logic [CNT_W-1:0] step_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FIRE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [7:0] c_db_last   = 8'(DB_CYCLES - 1);
    localparam logic [7:0] c_auto_last = 8'(AUTO_PERIOD - 1);

    state_t     r_state;
    logic [7:0] r_dbc;
    logic [7:0] r_div;

    logic       r_btn_q1;
    logic       r_btn_s;
    logic [1:0] r_sw_q1;
    logic [1:0] r_sw_s;

    logic       w_auto_tick;
    logic       w_arm_done;
    logic       w_pulse;

    // Two-flop synchronizers for the asynchronous button and switch inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_q1 <= 1'b0;
            r_btn_s  <= 1'b0;
            r_sw_q1  <= 2'b00;
            r_sw_s   <= 2'b00;
        end else begin
            r_btn_q1 <= btn_in;
            r_btn_s  <= r_btn_q1;
            r_sw_q1  <= sw_raw;
            r_sw_s   <= r_sw_q1;
        end
    end

    assign w_auto_tick = (r_state == IDLE) && auto_en && (r_div == c_auto_last);
    assign w_arm_done  = (r_state == ARM) && r_btn_s && (r_dbc == c_db_last);
    assign w_pulse     = w_auto_tick || w_arm_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_dbc      <= 8'd0;
            r_div      <= 8'd0;
            ctrl_out   <= 1'b0;
            sw_out     <= 2'b00;
            step_count <= '0;
        end else begin
            ctrl_out <= w_pulse;
            if (w_pulse) begin
                sw_out     <= r_sw_s;
                step_count <= step_count + CNT_W'(1);
            end

            // Divider only runs while idle with auto enabled.
            if ((r_state == IDLE) && auto_en)
                r_div <= w_auto_tick ? 8'd0 : r_div + 8'd1;
            else
                r_div <= 8'd0;

            case (r_state)
                IDLE: begin
                    if (r_btn_s) begin
                        r_state <= ARM;
                        r_dbc   <= 8'd0;
                    end
                end
                ARM: begin
                    if (!r_btn_s)
                        r_state <= IDLE;
                    else if (r_dbc == c_db_last)
                        r_state <= FIRE;
                    else
                        r_dbc <= r_dbc + 8'd1;
                end
                FIRE: begin
                    r_state <= HOLD;
                    r_dbc   <= 8'd0;
                end
                HOLD: begin
                    // Any high sample restarts the release debounce window.
                    if (r_btn_s)
                        r_dbc <= 8'd0;
                    else if (r_dbc == c_db_last)
                        r_state <= IDLE;
                    else
                        r_dbc <= r_dbc + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_step_ctrl.sv
`default_nettype none
// Scoreboard bench for step_ctrl: stimulus pushes expected pulses, a monitor
// pops and compares each ctrl_out pulse; direct checks cover idle/reset state.
module tb_step_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_in;
    logic [1:0] sw_raw;
    logic       auto_en;
    logic       ctrl_out;
    logic [1:0] sw_out;
    logic [7:0] step_count;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [1:0] sw;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;
    int   e0;
    int   k;

    step_ctrl #(.DB_CYCLES(DB), .AUTO_PERIOD(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .sw_raw     (sw_raw),
        .auto_en    (auto_en),
        .ctrl_out   (ctrl_out),
        .sw_out     (sw_out),
        .step_count (step_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] sw);
        exp_t e;
        exp_cnt++;
        e.cyc = c;
        e.sw  = sw;
        e.cnt = 8'(exp_cnt);
        sb.push_back(e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, 32'(ctrl_out), 0);
        chk({tag, "_sw"},   32'(sw_out), 0);
        chk({tag, "_cnt"},  32'(step_count), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn_in  = 1'b0;
        auto_en = 1'b0;
        reset   = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic drive(input logic v, input int n);
        btn_in = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        btn_in   = 1'b0;
        sw_raw   = 2'd0;
        auto_en  = 1'b0;
        reset    = 1'b1;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (ctrl_out === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                        chk("pulse_sw", 32'(sw_out), 32'(e.sw));
                        chk("pulse_count", 32'(step_count), 32'(e.cnt));
                    end
                end
            end
        join_none

        #1 reset = 1'b0;
        #1 chk_zero("init");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Held press: one pulse after edge DB+2
        sw_raw = 2'd2;
        repeat (3) @(negedge clk);
        btn_in = 1'b1;
        e0 = cyc + 1;
        push(e0 + DB + 2, 2'd2);
        repeat (4) @(negedge clk);
        chk("held_busy", 32'(busy), 1);
        repeat (16) @(negedge clk);
        drive(1'b0, 10);
        chk("held_idle", 32'(busy), 0);
        chk("held_cnt", 32'(step_count), 1);
        chk("held_sw", 32'(sw_out), 2);

        // Bounce during ARM: no pulse
        do_reset();
        drive(1'b1, 3);
        chk("bounce_arm_busy", 32'(busy), 1);
        drive(1'b0, 1);
        drive(1'b1, 2);
        drive(1'b0, 10);
        chk("bounce_idle", 32'(busy), 0);
        chk("bounce_cnt", 32'(step_count), 0);
        chk("bounce_sw", 32'(sw_out), 0);

        // Bounce during HOLD: single pulse, release needs DB stable lows
        do_reset();
        sw_raw = 2'd1;
        repeat (3) @(negedge clk);
        btn_in = 1'b1;
        e0 = cyc + 1;
        push(e0 + DB + 2, 2'd1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            btn_in = ~btn_in;
            repeat (2) @(negedge clk);
            chk("hold_toggle_busy", 32'(busy), 1);
        end
        btn_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_release_busy", 32'(busy), 1);
        @(negedge clk);
        chk("hold_release_idle", 32'(busy), 0);
        chk("hold_cnt", 32'(step_count), 1);

        // Auto-step, switch changing every 3 cycles
        do_reset();
        k = cyc + 1;
        for (int i = 0; i < 5; i++)
            push(k + 7 + 8 * i, 2'(((5 + 8 * i) / 3) % 4));
        for (int j = 0; j < 40; j++) begin
            auto_en = 1'b1;
            sw_raw  = 2'((j / 3) % 4);
            @(negedge clk);
        end
        auto_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("auto_cnt", 32'(step_count), 5);
        chk("auto_busy", 32'(busy), 0);

        // Counter wrap after 256 pulses
        do_reset();
        sw_raw = 2'd3;
        k = cyc + 1;
        for (int i = 0; i < 256; i++)
            push(k + 7 + 8 * i, 2'd3);
        auto_en = 1'b1;
        repeat (2040) @(negedge clk);
        chk("wrap_pre", 32'(step_count), 255);
        repeat (8) @(negedge clk);
        auto_en = 1'b0;
        chk("wrap_zero", 32'(step_count), 0);

        // Auto terminal count coinciding with IDLE->ARM
        do_reset();
        sw_raw = 2'd1;
        repeat (3) @(negedge clk);
        k = cyc + 1;
        push(k + 7, 2'd1);
        push(k + 11, 2'd1);
        for (int j = 0; j < 12; j++) begin
            auto_en = (j < 8);
            btn_in  = (j >= 5);
            @(negedge clk);
        end
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        drive(1'b0, 12);
        chk("coincide_idle", 32'(busy), 0);
        chk("coincide_cnt", 32'(step_count), 2);

        // Reset during ARM aborts the press; fresh debounce afterwards
        do_reset();
        sw_raw = 2'd2;
        repeat (3) @(negedge clk);
        btn_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("arm_busy", 32'(busy), 1);
        reset = 1'b0;
        #1 chk_zero("midrst");
        repeat (3) begin
            @(negedge clk);
            chk("midrst_ctrl", 32'(ctrl_out), 0);
        end
        reset   = 1'b1;
        exp_cnt = 0;
        e0 = cyc + 1;
        push(e0 + DB + 2, 2'd2);
        repeat (10) @(negedge clk);
        chk("postrst_cnt", 32'(step_count), 1);
        drive(1'b0, 10);
        chk("postrst_idle", 32'(busy), 0);

        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_ctrl.md
STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, the number of consecutive stable cycles needed to accept a button press or release (legal range 2..255).
REQ-002 SHALL have parameter AUTO_PERIOD, default 8, the auto-step pulse period in clocks (legal range 2..255).
REQ-003 SHALL have parameter CNT_W, default 8, the width of the step counter.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_in, input, 1 bit: raw, asynchronous, bouncing step button.
REQ-007 SHALL have port sw_raw, input, 2 bits: raw, asynchronous switch value.
REQ-008 SHALL have port auto_en, input, 1 bit: synchronous auto-step enable.
REQ-009 SHALL have port ctrl_out, output, 1 bit: one-cycle step-enable pulse, driving the FSM's ctrl_in.
REQ-010 SHALL have port sw_out, output, 2 bits: switch value held for the FSM's sw_in.
REQ-011 SHALL have port step_count, output, CNT_W bits: the number of steps issued.
REQ-012 SHALL have port busy, output, 1 bit: high while a manual press is in progress.

Function
REQ-013 SHALL pass btn_in and sw_raw each through a 2-flop synchronizer; btn_s and sw_s denote the second stage.
REQ-014 SHALL implement FSM states IDLE, ARM, FIRE and HOLD, with a debounce counter dbc.
REQ-015 IDLE: if btn_s=1, SHALL go to ARM with dbc=0; otherwise SHALL stay in IDLE.
REQ-016 ARM: if btn_s=0, SHALL go to IDLE; else if dbc=DB_CYCLES-1, SHALL go to FIRE; else SHALL increment dbc.
REQ-017 FIRE: SHALL last exactly one cycle, then go to HOLD with dbc=0.
REQ-018 HOLD: if btn_s=1, SHALL clear dbc; if btn_s=0 and dbc=DB_CYCLES-1, SHALL go to IDLE; otherwise SHALL increment dbc.
REQ-019 ctrl_out SHALL be a registered output, high for exactly the one cycle the FSM is in FIRE, or for one cycle on an auto pulse (REQ-021).
REQ-020 Manual latency SHALL be: first clk edge sampling btn_in=1 at edge 0, with btn_in held high, gives ctrl_out high in the cycle after edge DB_CYCLES+2.
REQ-021 Auto divider: SHALL count 0..AUTO_PERIOD-1 only while auto_en=1 and state=IDLE; it SHALL be cleared otherwise; at terminal count it SHALL wrap to 0 and pulse ctrl_out for one cycle.
REQ-022 With auto_en held high in IDLE, ctrl_out SHALL pulse exactly every AUTO_PERIOD cycles; the first pulse SHALL come AUTO_PERIOD cycles after auto_en is sampled high.
REQ-023 Simultaneous IDLE->ARM transition and auto terminal count: the auto pulse SHALL be issued, the divider SHALL clear, and ARM SHALL proceed normally.
REQ-024 sw_out SHALL load sw_s on the same edge that raises ctrl_out, and SHALL hold that value until the next pulse; it SHALL NOT change during a pulse cycle.
REQ-025 step_count SHALL increment by 1 on each ctrl_out pulse and wrap from 2^CNT_W-1 to 0.
REQ-026 busy SHALL be combinational, equal to (state != IDLE).
REQ-027 Bounce in ARM (any btn_s=0) SHALL return to IDLE and produce no pulse.
REQ-028 Bounce in HOLD SHALL produce no second pulse.
REQ-029 A press held indefinitely SHALL yield exactly one pulse.

Reset
REQ-030 While reset=0, the block SHALL force immediately: state=IDLE, dbc=0, divider=0, synchronizers=0, ctrl_out=0, sw_out=0, step_count=0.
REQ-031 Reset asserted mid-ARM/FIRE/HOLD SHALL abort the press with no pulse after release.
REQ-032 Reset deassertion SHALL be followed by normal operation from the next edge.

Verification
REQ-033 DB_CYCLES=4, sw_raw=2, btn_in high from edge 0 for 20 cycles -> ctrl_out high only in the cycle after edge 6; sw_out=2; step_count=1.
REQ-034 btn_in high 3 cycles, low 1, high 2, then low -> no ctrl_out pulse; state returns to IDLE; step_count=0.
REQ-035 Press accepted, then btn_in toggling every 2 cycles for 12 cycles before a stable release -> exactly one pulse; busy stays high until 4 stable-low cycles have elapsed.
REQ-036 AUTO_PERIOD=8, auto_en=1 for 40 cycles, sw_raw changing every 3 cycles -> 5 pulses spaced 8 cycles apart; each sw_out equals sw_s at its pulse edge; step_count=5.
REQ-037 CNT_W=8, preload 255 pulses, then one more -> step_count wraps to 0.
REQ-038 reset=0 asserted during ARM, then released with btn_in still high -> no pulse until a fresh full debounce of DB_CYCLES+2 edges; all outputs 0 during reset.
